// File: rtl/bsg_cache_buffer_drain.sv
// Store-buffer drain for the single-port data SRAM: pipeline reads win the port
// unless the head entry has starved long enough or a flush is draining the queue.
module bsg_cache_buffer_drain #(
    parameter int addr_width_p   = 6,
    parameter int data_width_p   = 16,
    parameter int starve_limit_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    v_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [data_width_p-1:0] data_i,
    output logic                    yumi_o,

    input  logic                    rd_v_i,
    input  logic [addr_width_p-1:0] rd_addr_i,
    output logic                    rd_stall_o,

    input  logic                    flush_i,
    output logic                    flush_busy_o,
    output logic                    flush_done_o,

    output logic                    sram_v_o,
    output logic                    sram_w_o,
    output logic [addr_width_p-1:0] sram_addr_o,
    output logic [data_width_p-1:0] sram_data_o,
    output logic                    rd_data_v_o
);

    localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(starve_limit_p);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp = cnt_width_lp'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    rd_data_v_q, rd_data_v_d;

    logic force_s;
    logic grant_s;

    // Port arbitration: a store takes the port when no read competes or when forced.
    always_comb begin
        force_s      = (cnt_q == cnt_max_lp) | (state_q == ST_FLUSH);
        grant_s      = v_i & (~rd_v_i | force_s);

        yumi_o       = grant_s;
        sram_w_o     = grant_s;
        sram_v_o     = grant_s | rd_v_i;
        sram_addr_o  = grant_s ? addr_i : rd_addr_i;
        sram_data_o  = data_i;
        rd_stall_o   = rd_v_i & grant_s;

        flush_busy_o = (state_q == ST_FLUSH);
        flush_done_o = (state_q == ST_FLUSH) & ~v_i;
        rd_data_v_o  = rd_data_v_q;
    end

    // Next-state: starvation counter, flush FSM and read-data-valid pipeline bit.
    always_comb begin
        cnt_d       = cnt_q;
        state_d     = state_q;
        rd_data_v_d = rd_v_i & ~grant_s;

        if (grant_s || !v_i) begin
            cnt_d = '0;
        end else if (rd_v_i && !force_s && (cnt_q != cnt_max_lp)) begin
            cnt_d = cnt_q + cnt_one_lp;
        end else begin
            cnt_d = cnt_q;
        end

        // A flush request arriving during FLUSH is absorbed by the ongoing drain.
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (!v_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset aborts any flush without a done pulse.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_data_v_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_data_v_q <= rd_data_v_d;
        end
    end

endmodule

// File: tb/tb_bsg_cache_buffer_drain.sv
// Directed bench for bsg_cache_buffer_drain with hand-computed expectations
// (addr 6b, data 16b, starvation limit 4).
module tb_bsg_cache_buffer_drain;

    logic        clk_i;
    logic        reset_n_i;
    logic        v_i;
    logic [5:0]  addr_i;
    logic [15:0] data_i;
    logic        yumi_o;
    logic        rd_v_i;
    logic [5:0]  rd_addr_i;
    logic        rd_stall_o;
    logic        flush_i;
    logic        flush_busy_o;
    logic        flush_done_o;
    logic        sram_v_o;
    logic        sram_w_o;
    logic [5:0]  sram_addr_o;
    logic [15:0] sram_data_o;
    logic        rd_data_v_o;

    int total_s;
    int bad_s;

    bsg_cache_buffer_drain #(
        .addr_width_p  (6),
        .data_width_p  (16),
        .starve_limit_p(4)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .v_i         (v_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .yumi_o      (yumi_o),
        .rd_v_i      (rd_v_i),
        .rd_addr_i   (rd_addr_i),
        .rd_stall_o  (rd_stall_o),
        .flush_i     (flush_i),
        .flush_busy_o(flush_busy_o),
        .flush_done_o(flush_done_o),
        .sram_v_o    (sram_v_o),
        .sram_w_o    (sram_w_o),
        .sram_addr_o (sram_addr_o),
        .sram_data_o (sram_data_o),
        .rd_data_v_o (rd_data_v_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_s++;
        if (got !== exp) begin
            bad_s++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next cycle: inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic v, input logic rd, input logic fl);
        v_i     = v;
        rd_v_i  = rd;
        flush_i = fl;
    endtask

    initial begin
        total_s   = 0;
        bad_s     = 0;
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        addr_i    = 6'h00;
        data_i    = 16'h0000;
        rd_v_i    = 1'b0;
        rd_addr_i = 6'h00;
        flush_i   = 1'b0;

        #3;
        chk("rst_yumi",  {31'd0, yumi_o},       32'd0);
        chk("rst_sramv", {31'd0, sram_v_o},     32'd0);
        chk("rst_rdv",   {31'd0, rd_data_v_o},  32'd0);
        chk("rst_busy",  {31'd0, flush_busy_o}, 32'd0);
        chk("rst_done",  {31'd0, flush_done_o}, 32'd0);
        chk("rst_stall", {31'd0, rd_stall_o},   32'd0);

        @(negedge clk_i);
        reset_n_i = 1'b1;
        next_cycle();

        // Uncontended store drains in the same cycle.
        set_in(1'b1, 1'b0, 1'b0);
        addr_i = 6'h05;
        data_i = 16'hBEEF;
        @(negedge clk_i);
        chk("w_yumi",  {31'd0, yumi_o},     32'd1);
        chk("w_sramv", {31'd0, sram_v_o},   32'd1);
        chk("w_sramw", {31'd0, sram_w_o},   32'd1);
        chk("w_addr",  {26'd0, sram_addr_o}, 32'h05);
        chk("w_data",  {16'd0, sram_data_o}, 32'hBEEF);
        chk("w_stall", {31'd0, rd_stall_o}, 32'd0);
        next_cycle();

        // Continuous reads starve the head entry until the 5th cycle.
        set_in(1'b1, 1'b1, 1'b0);
        addr_i    = 6'h11;
        rd_addr_i = 6'h22;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            chk($sformatf("st_yumi%0d", c),  {31'd0, yumi_o},     {31'd0, c == 4});
            chk($sformatf("st_stall%0d", c), {31'd0, rd_stall_o}, {31'd0, c == 4});
            chk($sformatf("st_rdv%0d", c),   {31'd0, rd_data_v_o}, {31'd0, (c >= 1) && (c <= 4)});
            chk($sformatf("st_addr%0d", c),  {26'd0, sram_addr_o}, (c == 4) ? 32'h11 : 32'h22);
            chk($sformatf("st_sramw%0d", c), {31'd0, sram_w_o},   {31'd0, c == 4});
            next_cycle();
        end

        set_in(1'b0, 1'b0, 1'b0);
        next_cycle();

        // Queue empties after 2 blocked cycles; starvation count restarts.
        for (int c = 0; c < 9; c++) begin
            set_in(c != 2, 1'b1, 1'b0);
            @(negedge clk_i);
            chk($sformatf("rs_yumi%0d", c), {31'd0, yumi_o}, {31'd0, c == 7});
            next_cycle();
        end

        set_in(1'b0, 1'b0, 1'b0);
        next_cycle();

        // Flush with two queued entries under continuous reads.
        for (int c = 0; c < 5; c++) begin
            set_in(c < 3, 1'b1, c == 0);
            @(negedge clk_i);
            chk($sformatf("fl_yumi%0d", c),  {31'd0, yumi_o},       {31'd0, (c == 1) || (c == 2)});
            chk($sformatf("fl_busy%0d", c),  {31'd0, flush_busy_o}, {31'd0, (c >= 1) && (c <= 3)});
            chk($sformatf("fl_done%0d", c),  {31'd0, flush_done_o}, {31'd0, c == 3});
            chk($sformatf("fl_stall%0d", c), {31'd0, rd_stall_o},   {31'd0, (c == 1) || (c == 2)});
            next_cycle();
        end

        set_in(1'b0, 1'b0, 1'b0);
        next_cycle();

        // Flush requested on an empty queue.
        for (int c = 0; c < 3; c++) begin
            set_in(1'b0, 1'b0, c == 0);
            @(negedge clk_i);
            chk($sformatf("fe_busy%0d", c), {31'd0, flush_busy_o}, {31'd0, c == 1});
            chk($sformatf("fe_done%0d", c), {31'd0, flush_done_o}, {31'd0, c == 1});
            next_cycle();
        end

        // Build count to 3, then assert reset asynchronously mid-cycle.
        set_in(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
        end
        @(negedge clk_i);
        chk("ar_pre_rdv",  {31'd0, rd_data_v_o}, 32'd1);
        chk("ar_pre_yumi", {31'd0, yumi_o},      32'd0);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("ar_rdv",  {31'd0, rd_data_v_o}, 32'd0);
        chk("ar_yumi", {31'd0, yumi_o},      32'd0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk($sformatf("ar_yumi%0d", c), {31'd0, yumi_o},      {31'd0, c == 4});
            chk($sformatf("ar_rdv%0d", c),  {31'd0, rd_data_v_o}, {31'd0, c >= 1});
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total_s, bad_s);
        $finish;
    end

endmodule
